mem_bus_ctrl: RTL
=================

# mem_bus_ctrl

Sequential data-memory access controller sitting directly downstream of the store-alignment/decode stage in the MEM pipeline stage. Accepts one aligned request per instruction and drives it onto the data-memory bus with a valid/ready handshake. It waits for read data, then extracts and sign/zero-extends the addressed byte lane and returns the load result. Stalls the pipeline for the whole access and reports bus errors and timeouts.

## Interface
- TIMEOUT, 64, cycles allowed in REQ+WAIT before abort; range 2..65535
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  upstream request (already masked by upstream bus error)
- req_op  in  2  00 disable, 01 load sext, 10 load zext, 11 store
- req_size  in  2  00 byte, 01 halfword, 10 word
- req_addr  in  32  byte address
- req_wen  in  4  lane write enables (0000 for loads)
- req_wdata  in  32  lane-aligned store data
- req_bus_err  in  1  upstream misalignment error
- stall  out  1  freeze pipeline (combinational)
- mem_valid  out  1  bus request valid
- mem_ready  in  1  bus accepts request
- mem_addr  out  32  registered request address
- mem_wen  out  4  registered lane enables; 0000 = read
- mem_wdata  out  32  registered store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data, lane-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  error flag, valid only with resp_valid
- resp_data  out  32  extended load result, held until next load completes

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if req_bus_err & req_op!=00 -> RESP with error, no bus cycle. Else if req_valid -> latch addr/wen/wdata/op/size, clear timer, -> REQ.
- REQ: mem_valid=1, fields stable. mem_ready=1: store -> RESP; load -> WAIT.
- WAIT: mem_valid=0; mem_rvalid=1 -> capture extended data -> RESP. mem_rdata ignored in every other state.
- RESP: resp_valid=1 for one cycle; always -> IDLE; request inputs ignored this cycle.
- Timer counts every cycle in REQ/WAIT; count reaching TIMEOUT-1 without completion in that cycle -> RESP with resp_err=1. mem_valid drops, resp_data unchanged. Completion wins over timeout in the same cycle.
- stall = rst_n & ((IDLE & (req_valid | (req_bus_err & req_op!=00))) | REQ | WAIT). Low in RESP, so the pipeline advances at the end of RESP.
- Lane extraction from latched addr[1:0]. Byte offset k is at bits [31-8k:24-8k]. Halfword offset 0 is at [31:16], offset 2 at [15:0]. Word takes all 32 bits.
- Extension: op 01 replicates the sign bit of the extracted byte/halfword; op 10 zero-fills. Word loads are unmodified.
- Stores and error responses leave resp_data unchanged.

## Timing
- Reset (async assert): state IDLE, mem_valid 0, mem_addr 0, mem_wen 0, mem_wdata 0, resp_valid 0, resp_err 0, resp_data 0, timer 0, stall 0 while rst_n low.
- Reset mid-access: mem_valid drops immediately. No resp_valid is produced. A late mem_rvalid after release is ignored.
- Best-case load: request in IDLE cycle 0, REQ+ready cycle 1, rvalid cycle 2, resp_valid cycle 3.
- Best-case store: resp_valid in cycle 2.
- Upstream error: resp_valid in cycle 1.
- Each extra mem_ready=0 or mem_rvalid=0 cycle adds one cycle.
- mem_addr/mem_wen/mem_wdata must not change while mem_valid=1 and mem_ready=0.
- Bus guarantees mem_rvalid is no earlier than the cycle after acceptance.
- Back-to-back accesses: minimum one IDLE cycle between RESP and the next REQ.

## Test plan
- Word load, addr 0x100, rdata 0x8899AABB, ready and rvalid immediate -> resp_valid in cycle 3, resp_data 0x8899AABB, resp_err 0; stall high cycles 0-2.
- Byte sext, addr 0x101, rdata 0x12F45678 -> resp_data 0xFFFFFFF4. Same request with op zext -> 0x000000F4.
- Halfword sext, addr 0x102, rdata 0x00008001 -> 0xFFFF8001.
- Store, wen 1100, wdata 0xBEEF0000, mem_ready low for 3 cycles -> fields stable, resp_valid in cycle 5, resp_data unchanged.
- Upstream error: req_bus_err=1, op 01 -> no mem_valid, resp_valid=resp_err=1 in cycle 1.
- TIMEOUT=4, load, mem_ready stuck 0 -> mem_valid low and resp_err=1 after 4 REQ cycles. A later rvalid is ignored. A reset asserted in WAIT returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the
// data memory (slave): request valid/ready handshake plus a read-data return.
interface mem_bus_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wen,
    output mem_wdata,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wen,
    input  mem_wdata,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-memory access controller: issues one aligned request per
// instruction, stalls until it completes, and returns the extended load result.
module mem_bus_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [3:0]            req_wen,
  input  logic [31:0]           req_wdata,
  input  logic                  req_bus_err,
  output logic                  stall,
  mem_bus_ctrl_if.master        bus,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_data
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0]  OP_SEXT    = 2'b01;
  localparam logic [1:0]  OP_STORE   = 2'b11;
  localparam logic [1:0]  SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  SIZE_HALF  = 2'b01;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;
  logic [1:0]  op_q;
  logic [1:0]  size_q;
  logic [15:0] timer;
  logic        err_q;

  logic        upstream_err;
  logic        timer_expired;
  logic        is_store;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  assign upstream_err  = req_bus_err && (req_op != 2'b00);
  assign timer_expired = (timer >= TIMER_LAST);
  assign is_store      = (op_q == OP_STORE);

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A handshake that completes in the last allowed cycle beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (upstream_err) begin
          state_next = RESP;
        end else if (req_valid) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          state_next = is_store ? RESP : WAIT;
        end else if (timer_expired) begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid || timer_expired) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request fields are latched once on acceptance so the bus sees them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      size_q    <= '0;
      timer     <= '0;
      err_q     <= 1'b0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upstream_err) begin
            err_q <= 1'b1;
          end else if (req_valid) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            op_q    <= req_op;
            size_q  <= req_size;
            timer   <= '0;
            err_q   <= 1'b0;
          end
        end
        REQ: begin
          timer <= timer + 16'd1;
          if (!bus.mem_ready && timer_expired) begin
            err_q <= 1'b1;
          end
        end
        WAIT: begin
          timer <= timer + 16'd1;
          if (bus.mem_rvalid) begin
            resp_data <= load_data;
          end else if (timer_expired) begin
            err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte offset k sits at [31-8k:24-8k]; halfword offset 0 is the upper half.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    load_data = bus.mem_rdata;
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.mem_rdata[31:24];
      2'd1:    byte_lane = bus.mem_rdata[23:16];
      2'd2:    byte_lane = bus.mem_rdata[15:8];
      default: byte_lane = bus.mem_rdata[7:0];
    endcase
    half_lane = addr_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    if (size_q == SIZE_BYTE) begin
      load_data = (op_q == OP_SEXT) ? {{24{byte_lane[7]}}, byte_lane}
                                    : {24'h000000, byte_lane};
    end else if (size_q == SIZE_HALF) begin
      load_data = (op_q == OP_SEXT) ? {{16{half_lane[15]}}, half_lane}
                                    : {16'h0000, half_lane};
    end
  end

  always_comb begin
    stall         = 1'b0;
    bus.mem_valid = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid || upstream_err;
      end
      REQ: begin
        stall         = 1'b1;
        bus.mem_valid = 1'b1;
      end
      WAIT: begin
        stall = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: begin
      end
    endcase
    stall = stall && rst_n;
  end

endmodule
